// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache memory-port arbiter: FSM states, requester IDs
// and the round-robin pick used to resolve simultaneous requests.
package cache_mem_arbiter_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } requester_t;

    // Two-way round-robin: on a tie the requester that did not win last time goes next.
    function automatic requester_t rr_pick(input logic i_active,
                                           input logic d_active,
                                           input requester_t last_grant);
        requester_t pick;
        if (i_active && d_active) begin
            if (last_grant == REQ_I) pick = REQ_D;
            else                     pick = REQ_I;
        end else if (d_active) begin
            pick = REQ_D;
        end else begin
            pick = REQ_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals around the arbiter.
// The arbiter takes the slave view; the caches/memory environment takes master.
interface cache_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);

    logic [ADDR_WIDTH-1:0] i_dfp_addr;
    logic                  i_dfp_read;
    logic                  i_dfp_write;
    logic [LINE_WIDTH-1:0] i_dfp_wdata;
    logic [LINE_WIDTH-1:0] i_dfp_rdata;
    logic                  i_dfp_resp;

    logic [ADDR_WIDTH-1:0] d_dfp_addr;
    logic                  d_dfp_read;
    logic                  d_dfp_write;
    logic [LINE_WIDTH-1:0] d_dfp_wdata;
    logic [LINE_WIDTH-1:0] d_dfp_rdata;
    logic                  d_dfp_resp;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read;
    logic                  mem_write;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  i_dfp_addr, i_dfp_read, i_dfp_write, i_dfp_wdata,
        output i_dfp_rdata, i_dfp_resp,
        input  d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
        output d_dfp_rdata, d_dfp_resp,
        output mem_addr, mem_read, mem_write, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output i_dfp_addr, i_dfp_read, i_dfp_write, i_dfp_wdata,
        input  i_dfp_rdata, i_dfp_resp,
        output d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
        input  d_dfp_rdata, d_dfp_resp,
        input  mem_addr, mem_read, mem_write, mem_wdata,
        output mem_rdata, mem_resp
    );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one cacheline-wide memory port between the I-cache and D-cache.
// One transaction in flight; ownership is latched at grant and held until mem_resp.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input logic clk,
    input logic rst,
    cache_mem_arbiter_if.slave bus
);

    arb_state_t state;
    arb_state_t next_state;
    requester_t owner;
    requester_t last_grant;
    requester_t pick;

    logic                  i_active;
    logic                  d_active;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [LINE_WIDTH-1:0] next_wdata;
    logic                  next_read;
    logic                  next_write;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Write wins if a requester raises both strobes; that case is flagged by the assertion below.
    always_comb begin
        i_active       = bus.i_dfp_read | bus.i_dfp_write;
        d_active       = bus.d_dfp_read | bus.d_dfp_write;
        pick           = rr_pick(i_active, d_active, last_grant);
        next_state     = state;
        grant          = 1'b0;
        bus.i_dfp_resp = 1'b0;
        bus.d_dfp_resp = 1'b0;
        if (pick == REQ_I) begin
            next_addr  = bus.i_dfp_addr;
            next_wdata = bus.i_dfp_wdata;
            next_write = bus.i_dfp_write;
            next_read  = bus.i_dfp_read & ~bus.i_dfp_write;
        end else begin
            next_addr  = bus.d_dfp_addr;
            next_wdata = bus.d_dfp_wdata;
            next_write = bus.d_dfp_write;
            next_read  = bus.d_dfp_read & ~bus.d_dfp_write;
        end
        case (state)
            IDLE: begin
                if (i_active || d_active) begin
                    grant      = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_resp) begin
                    bus.i_dfp_resp = (owner == REQ_I);
                    bus.d_dfp_resp = (owner == REQ_D);
                    next_state     = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.i_dfp_rdata = bus.mem_rdata;
    assign bus.d_dfp_rdata = bus.mem_rdata;

    // Memory-side registers load only at grant, so they stay frozen for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            owner         <= REQ_I;
            last_grant    <= REQ_D;
        end else if (grant) begin
            bus.mem_addr  <= next_addr;
            bus.mem_wdata <= next_wdata;
            bus.mem_read  <= next_read;
            bus.mem_write <= next_write;
            owner         <= pick;
            last_grant    <= pick;
        end else if (state == BUSY && bus.mem_resp) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
        end
    end

    i_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(bus.i_dfp_read && bus.i_dfp_write));
    d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(bus.d_dfp_read && bus.d_dfp_write));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a per-cycle vector table for arbitration
// and read traffic, then hand-written sequences for writes, held outputs and reset.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    localparam logic [31:0]  IA = 32'h0000_1000;
    localparam logic [31:0]  DA = 32'h0000_3000;
    localparam logic [255:0] LINE_DEAD = {8{32'hDEAD_BEEF}};

    typedef struct {
        logic        ir;
        logic        dr;
        logic        mresp;
        logic        e_iresp;
        logic        e_dresp;
        logic        e_mrd;
        logic [31:0] e_addr;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[24];

    cache_mem_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) bus ();

    cache_mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ir, input logic dr, input logic mresp,
                                input logic e_iresp, input logic e_dresp,
                                input logic e_mrd, input logic [31:0] e_addr);
        vec_t v;
        v.ir = ir; v.dr = dr; v.mresp = mresp;
        v.e_iresp = e_iresp; v.e_dresp = e_dresp; v.e_mrd = e_mrd; v.e_addr = e_addr;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v, input logic [255:0] line);
        bus.i_dfp_read  = v.ir;
        bus.i_dfp_write = 1'b0;
        bus.i_dfp_addr  = IA;
        bus.d_dfp_read  = v.dr;
        bus.d_dfp_write = 1'b0;
        bus.d_dfp_addr  = DA;
        bus.mem_resp    = v.mresp;
        bus.mem_rdata   = line;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [255:0] line;
        checks = 0;
        errors = 0;

        // Row columns: i_read, d_read, mem_resp | exp i_resp, d_resp, mem_read, mem_addr
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 32'h0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 1, IA);
        vecs[2]  = mk(1, 1, 1, 1, 0, 1, IA);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0, IA);
        vecs[4]  = mk(0, 1, 0, 0, 0, 1, DA);
        vecs[5]  = mk(0, 1, 1, 0, 1, 1, DA);
        vecs[6]  = mk(1, 1, 0, 0, 0, 0, DA);
        vecs[7]  = mk(1, 1, 0, 0, 0, 1, IA);
        vecs[8]  = mk(1, 1, 1, 1, 0, 1, IA);
        vecs[9]  = mk(0, 1, 0, 0, 0, 0, IA);
        vecs[10] = mk(0, 1, 1, 0, 1, 1, DA);
        vecs[11] = mk(1, 0, 0, 0, 0, 0, DA);
        for (int r = 12; r <= 16; r++) vecs[r] = mk(1, 0, 0, 0, 0, 1, IA);
        vecs[17] = mk(1, 0, 1, 1, 0, 1, IA);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, IA);
        vecs[19] = mk(0, 0, 1, 0, 0, 0, IA);
        vecs[20] = mk(0, 1, 0, 0, 0, 0, IA);
        vecs[21] = mk(0, 1, 0, 0, 0, 1, DA);
        vecs[22] = mk(0, 1, 1, 0, 1, 1, DA);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, DA);

        rst = 1'b1;
        bus.i_dfp_wdata = '0;
        bus.d_dfp_wdata = '0;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0), '0);
        next_cycle();
        next_cycle();
        #2;
        checkOutput("reset mem_read", bus.mem_read, 0);
        checkOutput("reset mem_write", bus.mem_write, 0);
        checkOutput("reset mem_addr", bus.mem_addr, 0);
        checkOutput("reset mem_wdata", bus.mem_wdata, 0);
        checkOutput("reset i_resp", bus.i_dfp_resp, 0);
        checkOutput("reset d_resp", bus.d_dfp_resp, 0);

        for (int i = 0; i < 24; i++) begin
            next_cycle();
            if (i == 0) rst = 1'b0;
            line = {8{32'hA5A5_0000 + 32'(i)}};
            applyStimulus(vecs[i], line);
            #2;
            checkOutput($sformatf("row%0d i_resp", i), bus.i_dfp_resp, vecs[i].e_iresp);
            checkOutput($sformatf("row%0d d_resp", i), bus.d_dfp_resp, vecs[i].e_dresp);
            checkOutput($sformatf("row%0d mem_read", i), bus.mem_read, vecs[i].e_mrd);
            checkOutput($sformatf("row%0d mem_write", i), bus.mem_write, 0);
            checkOutput($sformatf("row%0d mem_addr", i), bus.mem_addr, vecs[i].e_addr);
            if (vecs[i].e_iresp) checkOutput($sformatf("row%0d i_rdata", i), bus.i_dfp_rdata, line);
            if (vecs[i].e_dresp) checkOutput($sformatf("row%0d d_rdata", i), bus.d_dfp_rdata, line);
        end

        // D writeback, I read arrives mid-write, D allocate read raised right after resp.
        next_cycle();
        bus.d_dfp_write = 1'b1; bus.d_dfp_addr = 32'h0000_2020; bus.d_dfp_wdata = LINE_DEAD;
        #2; checkOutput("wr idle mem_write", bus.mem_write, 0);
        next_cycle();
        bus.i_dfp_read = 1'b1; bus.i_dfp_addr = IA;
        #2;
        checkOutput("wr mem_write", bus.mem_write, 1);
        checkOutput("wr mem_read", bus.mem_read, 0);
        checkOutput("wr mem_addr", bus.mem_addr, 32'h0000_2020);
        checkOutput("wr mem_wdata", bus.mem_wdata, LINE_DEAD);
        next_cycle();
        bus.d_dfp_wdata = ~LINE_DEAD;
        #2; checkOutput("wr wdata held", bus.mem_wdata, LINE_DEAD);
        next_cycle();
        bus.mem_resp = 1'b1;
        #2;
        checkOutput("wr d_resp", bus.d_dfp_resp, 1);
        checkOutput("wr i_resp", bus.i_dfp_resp, 0);
        checkOutput("wr wdata at resp", bus.mem_wdata, LINE_DEAD);
        next_cycle();
        bus.mem_resp = 1'b0; bus.d_dfp_write = 1'b0; bus.d_dfp_read = 1'b1; bus.d_dfp_addr = 32'h0000_4020;
        #2;
        checkOutput("post wr mem_write", bus.mem_write, 0);
        checkOutput("post wr d_resp", bus.d_dfp_resp, 0);
        next_cycle();
        #2;
        checkOutput("rearb I mem_read", bus.mem_read, 1);
        checkOutput("rearb I mem_addr", bus.mem_addr, IA);
        next_cycle();
        bus.mem_resp = 1'b1;
        #2;
        checkOutput("rearb i_resp", bus.i_dfp_resp, 1);
        checkOutput("rearb d_resp", bus.d_dfp_resp, 0);
        next_cycle();
        bus.mem_resp = 1'b0; bus.i_dfp_read = 1'b0;
        #2; checkOutput("alloc idle mem_read", bus.mem_read, 0);
        next_cycle();
        bus.mem_resp = 1'b1;
        #2;
        checkOutput("alloc mem_addr", bus.mem_addr, 32'h0000_4020);
        checkOutput("alloc d_resp", bus.d_dfp_resp, 1);

        // Address changes while BUSY must not reach mem_addr.
        next_cycle();
        bus.mem_resp = 1'b0; bus.d_dfp_addr = 32'h0000_6000;
        #2; checkOutput("hold idle mem_read", bus.mem_read, 0);
        next_cycle();
        bus.d_dfp_addr = 32'h0000_7000;
        #2; checkOutput("hold mem_addr", bus.mem_addr, 32'h0000_6000);
        next_cycle();
        bus.mem_resp = 1'b1;
        #2;
        checkOutput("hold mem_addr at resp", bus.mem_addr, 32'h0000_6000);
        checkOutput("hold d_resp", bus.d_dfp_resp, 1);
        next_cycle();
        bus.mem_resp = 1'b0; bus.d_dfp_read = 1'b0;
        #2; checkOutput("hold done mem_read", bus.mem_read, 0);

        // Reset during BUSY, then a stray mem_resp, then a fresh request.
        next_cycle();
        bus.i_dfp_read = 1'b1; bus.i_dfp_addr = 32'h0000_8000;
        next_cycle();
        #2; checkOutput("rst busy mem_read", bus.mem_read, 1);
        rst = 1'b1; bus.i_dfp_read = 1'b0;
        next_cycle();
        rst = 1'b0;
        #2;
        checkOutput("rst mem_read", bus.mem_read, 0);
        checkOutput("rst mem_addr", bus.mem_addr, 0);
        checkOutput("rst mem_wdata", bus.mem_wdata, 0);
        checkOutput("rst i_resp", bus.i_dfp_resp, 0);
        next_cycle();
        bus.mem_resp = 1'b1;
        #2;
        checkOutput("stray i_resp", bus.i_dfp_resp, 0);
        checkOutput("stray d_resp", bus.d_dfp_resp, 0);
        next_cycle();
        bus.mem_resp = 1'b0; bus.d_dfp_read = 1'b1; bus.d_dfp_addr = 32'h0000_A000;
        #2; checkOutput("after rst idle mem_read", bus.mem_read, 0);
        next_cycle();
        bus.mem_resp = 1'b1;
        #2;
        checkOutput("after rst mem_read", bus.mem_read, 1);
        checkOutput("after rst mem_addr", bus.mem_addr, 32'h0000_A000);
        checkOutput("after rst d_resp", bus.d_dfp_resp, 1);
        next_cycle();
        bus.mem_resp = 1'b0; bus.d_dfp_read = 1'b0;
        #2; checkOutput("final mem_read", bus.mem_read, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
